// File: rtl/fetch_mem_responder.sv
// Instruction-fetch memory responder.
// Serves one outstanding fetch request at a time from a preloadable word
// store. The response appears a fixed number of cycles after the request is
// accepted, and it is held until the consumer takes it. Requests that are
// misaligned or past the end of storage return an error flag with zero data.
module fetch_mem_responder #(
  parameter int P_ADDR_WIDTH  = 32,
  parameter int P_DATA_WIDTH  = 32,
  parameter int P_DEPTH_WORDS = 1024,
  parameter int P_LATENCY     = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [P_ADDR_WIDTH-1:0] i_req_addr,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [P_DATA_WIDTH-1:0] o_rsp_data,
  output logic [P_ADDR_WIDTH-1:0] o_rsp_addr,
  output logic                    o_rsp_err,
  input  logic                    i_ld_en,
  input  logic [P_ADDR_WIDTH-1:0] i_ld_addr,
  input  logic [P_DATA_WIDTH-1:0] i_ld_data
);

  localparam int IDX_W = $clog2(P_DEPTH_WORDS);

  // Number of whole WAIT cycles after the accept edge; unused when the
  // latency is a single cycle because the FSM goes straight to RESP.
  localparam logic [1:0] CNT_INIT = (P_LATENCY >= 2) ? 2'(P_LATENCY - 2) : 2'd0;

  localparam logic [P_ADDR_WIDTH-1:0] DEPTH_LIMIT = P_ADDR_WIDTH'(P_DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // Where an accepted request goes on the accept edge.
  localparam state_t ACCEPT_TARGET = (P_LATENCY == 1) ? S_RESP : S_WAIT;

  state_t                  state;
  state_t                  state_next;
  logic [1:0]              cnt;
  logic [P_ADDR_WIDTH-1:0] pend_addr;

  logic                    accept;
  logic                    capture;
  logic [P_ADDR_WIDTH-1:0] cap_addr;
  logic [P_ADDR_WIDTH-1:0] cap_word;
  logic [IDX_W-1:0]        cap_idx;
  logic                    cap_err;
  logic [P_ADDR_WIDTH-1:0] ld_word;
  logic [IDX_W-1:0]        ld_idx;
  logic                    ld_ok;

  logic [P_DATA_WIDTH-1:0] mem [P_DEPTH_WORDS];

  // A request is taken only while the handshake is open.
  assign accept = i_req_valid && o_req_ready;

  // The word is read on the edge that enters RESP: either the WAIT->RESP
  // edge or, for single-cycle latency, the accept edge itself. A RESP that
  // is merely holding for the consumer never recaptures.
  assign capture = (state_next == S_RESP) && ((state == S_WAIT) || accept);

  // With single-cycle latency the request address is still on the port at
  // the capture edge; otherwise it was parked in pend_addr at accept.
  assign cap_addr = (P_LATENCY == 1) ? i_req_addr : pend_addr;
  assign cap_word = cap_addr >> 2;
  assign cap_idx  = cap_word[IDX_W-1:0];
  assign cap_err  = (cap_addr[1:0] != 2'b00) || (cap_word >= DEPTH_LIMIT);

  // Preload addresses are word addresses in byte units; the low two bits
  // are dropped and anything past the end of storage is discarded rather
  // than aliased onto a low word.
  assign ld_word = i_ld_addr >> 2;
  assign ld_idx  = ld_word[IDX_W-1:0];
  assign ld_ok   = (ld_word < DEPTH_LIMIT);

  // State register and latency counter; reset wins over everything.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt <= CNT_INIT;
      end else if ((state == S_WAIT) && (cnt != 2'd0)) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

  // Next-state decode; flush overrides any handshake-driven transition.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = ACCEPT_TARGET;
        end
      end
      S_WAIT: begin
        if (cnt == 2'd0) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          state_next = accept ? ACCEPT_TARGET : S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (i_flush) begin
      state_next = S_IDLE;
    end
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    if (!i_flush && ((state == S_IDLE) || ((state == S_RESP) && i_rsp_ready))) begin
      o_req_ready = 1'b1;
    end
    if (state == S_RESP) begin
      o_rsp_valid = 1'b1;
    end
  end

  // Park the request address at accept for the later capture edge.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      pend_addr <= i_req_addr;
    end
  end

  // Response payload: captured once on entering RESP, then held stable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp_data <= '0;
      o_rsp_addr <= '0;
      o_rsp_err  <= 1'b0;
    end else if (capture) begin
      o_rsp_addr <= cap_addr;
      o_rsp_err  <= cap_err;
      o_rsp_data <= cap_err ? '0 : mem[cap_idx];
    end
  end

  // Preload port into word storage; a same-edge read of the same word
  // sees the old contents because both sides sample before the update.
  // NOTE: storage is deliberately not reset so preloaded code survives a
  // reset, and so it can map onto plain RAM without a clear path.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_ld_en && ld_ok) begin
      mem[ld_idx] <= i_ld_data;
    end
  end

endmodule

// File: tb/tb_fetch_mem_responder.sv
// Bench for fetch_mem_responder: a latency-2 instance carries most of the
// tests, a latency-1 instance carries the back-to-back streaming case.
// Expected responses go into per-instance queues as requests are driven and
// are popped by monitors whenever a response handshake is observed.
module tb_fetch_mem_responder;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  logic          a_flush, a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [AW-1:0] a_req_addr, a_rsp_addr;
  logic [DW-1:0] a_rsp_data;

  logic          b_flush, b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [AW-1:0] b_req_addr, b_rsp_addr;
  logic [DW-1:0] b_rsp_data;

  fetch_mem_responder #(
    .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_DEPTH_WORDS(DEPTH), .P_LATENCY(LAT_A)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_flush(a_flush),
    .i_req_valid(a_req_valid), .o_req_ready(a_req_ready), .i_req_addr(a_req_addr),
    .o_rsp_valid(a_rsp_valid), .i_rsp_ready(a_rsp_ready), .o_rsp_data(a_rsp_data),
    .o_rsp_addr(a_rsp_addr), .o_rsp_err(a_rsp_err),
    .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
  );

  fetch_mem_responder #(
    .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_DEPTH_WORDS(DEPTH), .P_LATENCY(LAT_B)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_flush(b_flush),
    .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_addr(b_req_addr),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready), .o_rsp_data(b_rsp_data),
    .o_rsp_addr(b_rsp_addr), .o_rsp_err(b_rsp_err),
    .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  rsp_t sb_a[$];
  rsp_t sb_b[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: a response is consumed when valid and ready are
  // both high at the sampling point ahead of the rising edge.
  always @(negedge clk) begin : mon_a
    rsp_t e;
    if (rst === 1'b0 && a_rsp_valid === 1'b1 && a_rsp_ready === 1'b1) begin
      if (sb_a.size() == 0) begin
        check("a_unexpected_rsp", 32'(a_rsp_valid), 32'd0);
      end else begin
        e = sb_a.pop_front();
        check("a_rsp_addr", a_rsp_addr, e.addr);
        check("a_rsp_data", a_rsp_data, e.data);
        check("a_rsp_err", 32'(a_rsp_err), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    rsp_t e;
    if (rst === 1'b0 && b_rsp_valid === 1'b1 && b_rsp_ready === 1'b1) begin
      if (sb_b.size() == 0) begin
        check("b_unexpected_rsp", 32'(b_rsp_valid), 32'd0);
      end else begin
        e = sb_b.pop_front();
        check("b_rsp_addr", b_rsp_addr, e.addr);
        check("b_rsp_data", b_rsp_data, e.data);
        check("b_rsp_err", 32'(b_rsp_err), 32'(e.err));
      end
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    step();
    ld_en   = 1'b0;
  endtask

  task automatic push_a(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic err);
    rsp_t e;
    e.addr = addr;
    e.data = data;
    e.err  = err;
    sb_a.push_back(e);
  endtask

  task automatic push_b(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic err);
    rsp_t e;
    e.addr = addr;
    e.data = data;
    e.err  = err;
    sb_b.push_back(e);
  endtask

  // Single request on instance A with the consumer always ready; checks
  // that valid appears exactly LAT_A edges after the accept edge.
  task automatic do_req(input logic [AW-1:0] addr, input logic [DW-1:0] dat,
                        input logic err, input string nm);
    a_req_valid = 1'b1;
    a_req_addr  = addr;
    a_rsp_ready = 1'b1;
    @(negedge clk);
    check({nm, "_req_ready"}, 32'(a_req_ready), 32'd1);
    push_a(addr, dat, err);
    step();
    a_req_valid = 1'b0;
    for (int k = 1; k < LAT_A; k++) begin
      @(negedge clk);
      check({nm, "_early"}, 32'(a_rsp_valid), 32'd0);
      step();
    end
    @(negedge clk);
    check({nm, "_valid"}, 32'(a_rsp_valid), 32'd1);
    step();
    @(negedge clk);
    check({nm, "_done"}, 32'(a_rsp_valid), 32'd0);
    step();
  endtask

  vec_t vecs[8];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_0010, 32'h0050_0093, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0013, 1'b0};
    vecs[2] = '{32'h0000_0008, 32'h0020_0193, 1'b0};
    vecs[3] = '{32'h0000_0FFC, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{32'h0000_0012, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h0000_0003, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h0000_1000, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'h8000_0010, 32'h0000_0000, 1'b1};

    rst = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    a_flush = 1'b0; a_req_valid = 1'b0; a_req_addr = '0; a_rsp_ready = 1'b0;
    b_flush = 1'b0; b_req_valid = 1'b0; b_req_addr = '0; b_rsp_ready = 1'b0;
    step();
    step();

    // Reset state on both instances.
    @(negedge clk);
    check("rst_a_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_a_data", a_rsp_data, 32'd0);
    check("rst_a_addr", a_rsp_addr, 32'd0);
    check("rst_a_err", 32'(a_rsp_err), 32'd0);
    check("rst_a_ready", 32'(a_req_ready), 32'd1);
    check("rst_b_valid", 32'(b_rsp_valid), 32'd0);
    check("rst_b_data", b_rsp_data, 32'd0);
    step();
    rst = 1'b0;

    // Preload; word 2 through an address with nonzero low bits, and one
    // out-of-range load that would alias word 0 if it wrapped.
    load(32'h0000_0000, 32'h0000_0013);
    load(32'h0000_0004, 32'h0010_0113);
    load(32'h0000_000A, 32'h0020_0193);
    load(32'h0000_0010, 32'h0050_0093);
    load(32'h0000_0FFC, 32'hCAFE_F00D);
    load(32'h0000_1000, 32'hBAD0_BAD0);

    // Table: normal reads, last word, misaligned, out-of-range, no wrap.
    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Consumer stalls for three cycles in RESP, then releases.
    push_a(32'h4, 32'h0010_0113, 1'b0);
    a_req_valid = 1'b1;
    a_req_addr  = 32'h4;
    a_rsp_ready = 1'b0;
    step();
    a_req_valid = 1'b0;
    for (int k = 1; k < LAT_A; k++) step();
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", h), 32'(a_rsp_valid), 32'd1);
      check($sformatf("hold%0d_data", h), a_rsp_data, 32'h0010_0113);
      check($sformatf("hold%0d_addr", h), a_rsp_addr, 32'h4);
      check($sformatf("hold%0d_req_ready", h), 32'(a_req_ready), 32'd0);
      step();
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    check("hold_release_ready", 32'(a_req_ready), 32'd1);
    step();
    @(negedge clk);
    check("hold_idle_valid", 32'(a_rsp_valid), 32'd0);
    check("hold_idle_ready", 32'(a_req_ready), 32'd1);
    step();

    // Flush while in WAIT; a competing request must not be accepted.
    a_req_valid = 1'b1;
    a_req_addr  = 32'h8;
    a_rsp_ready = 1'b1;
    step();
    a_req_addr = 32'h0;
    a_flush    = 1'b1;
    @(negedge clk);
    check("flush_wait_ready", 32'(a_req_ready), 32'd0);
    step();
    a_flush     = 1'b0;
    a_req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("flush_wait_quiet%0d", k), 32'(a_rsp_valid), 32'd0);
      step();
    end

    // Flush while in RESP with the consumer stalled.
    a_req_valid = 1'b1;
    a_req_addr  = 32'h10;
    a_rsp_ready = 1'b0;
    step();
    a_req_valid = 1'b0;
    for (int k = 1; k < LAT_A; k++) step();
    @(negedge clk);
    check("flush_resp_pre", 32'(a_rsp_valid), 32'd1);
    a_flush = 1'b1;
    step();
    a_flush     = 1'b0;
    a_rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("flush_resp_quiet%0d", k), 32'(a_rsp_valid), 32'd0);
      step();
    end

    // Reset mid-WAIT with a load attempted during reset.
    a_req_valid = 1'b1;
    a_req_addr  = 32'h4;
    step();
    a_req_valid = 1'b0;
    rst     = 1'b1;
    ld_en   = 1'b1;
    ld_addr = 32'h10;
    ld_data = 32'h1234_5678;
    step();
    rst   = 1'b0;
    ld_en = 1'b0;
    @(negedge clk);
    check("rst_wait_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_wait_data", a_rsp_data, 32'd0);
    check("rst_wait_addr", a_rsp_addr, 32'd0);
    check("rst_wait_err", 32'(a_rsp_err), 32'd0);
    check("rst_wait_ready", 32'(a_req_ready), 32'd1);
    step();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("rst_wait_quiet%0d", k), 32'(a_rsp_valid), 32'd0);
      step();
    end
    do_req(32'h10, 32'h0050_0093, 1'b0, "retained");

    // Load to word 4 on the same edge the FSM enters RESP for 0x10.
    push_a(32'h10, 32'h0050_0093, 1'b0);
    a_req_valid = 1'b1;
    a_req_addr  = 32'h10;
    a_rsp_ready = 1'b1;
    step();
    a_req_valid = 1'b0;
    ld_en   = 1'b1;
    ld_addr = 32'h10;
    ld_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("ldcol_early", 32'(a_rsp_valid), 32'd0);
    step();
    ld_en = 1'b0;
    @(negedge clk);
    check("ldcol_valid", 32'(a_rsp_valid), 32'd1);
    step();
    do_req(32'h10, 32'hDEAD_BEEF, 1'b0, "after_ld");

    // Latency-1 instance: back-to-back requests, one response per cycle.
    push_b(32'h0, 32'h0000_0013, 1'b0);
    push_b(32'h4, 32'h0010_0113, 1'b0);
    push_b(32'h8, 32'h0020_0193, 1'b0);
    b_rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_req_valid = 1'b1;
      b_req_addr  = 32'(i * 4);
      @(negedge clk);
      check($sformatf("b2b%0d_ready", i), 32'(b_req_ready), 32'd1);
      if (i > 0) check($sformatf("b2b%0d_valid", i), 32'(b_rsp_valid), 32'd1);
      step();
    end
    b_req_valid = 1'b0;
    @(negedge clk);
    check("b2b_last_valid", 32'(b_rsp_valid), 32'd1);
    step();
    @(negedge clk);
    check("b2b_idle_valid", 32'(b_rsp_valid), 32'd0);
    step();

    check("sb_a_drained", 32'(sb_a.size()), 32'd0);
    check("sb_b_drained", 32'(sb_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_mem_responder.md
FETCH_MEM_RESPONDER -- requirements
Module: fetch_mem_responder

Interface
REQ-001 Parameter P_ADDR_WIDTH, default 32, byte-address width of request and load ports.
REQ-002 Parameter P_DATA_WIDTH, default 32, instruction word width.
REQ-003 Parameter P_DEPTH_WORDS, default 1024, number of words in storage; power of two.
REQ-004 Parameter P_LATENCY, default 2, request-to-response cycles; legal range 1..4.
REQ-005 The block SHALL have one clock and a synchronous active-high reset: ports i_clk then i_rst.
REQ-006 i_clk  input  1  clock; all state updates on rising edge.
REQ-007 i_rst  input  1  synchronous active-high reset.
REQ-008 i_flush  input  1  abort any pending request or response.
REQ-009 i_req_valid  input  1  fetch request present.
REQ-010 o_req_ready  output  1  request accepted this cycle when high with i_req_valid.
REQ-011 i_req_addr  input  P_ADDR_WIDTH  byte address of instruction.
REQ-012 o_rsp_valid  output  1  response present.
REQ-013 i_rsp_ready  input  1  consumer takes response this cycle.
REQ-014 o_rsp_data  output  P_DATA_WIDTH  instruction word.
REQ-015 o_rsp_addr  output  P_ADDR_WIDTH  address of the request being answered.
REQ-016 o_rsp_err  output  1  misaligned or out-of-range request.
REQ-017 i_ld_en  input  1  preload write strobe.
REQ-018 i_ld_addr  input  P_ADDR_WIDTH  preload byte address; bits [1:0] ignored.
REQ-019 i_ld_data  input  P_DATA_WIDTH  preload data.

Function
REQ-020 FSM states SHALL be IDLE, WAIT, RESP; one request outstanding at most.
REQ-021 o_req_ready SHALL be 1 when not i_flush and (state IDLE, or state RESP with i_rsp_ready=1); combinational.
REQ-022 Request accepted at edge T (valid&ready) SHALL produce o_rsp_valid=1 first in cycle T+P_LATENCY.
REQ-023 On accept: P_LATENCY=1 -> RESP next; else -> WAIT with counter = P_LATENCY-2, decrement each cycle, WAIT->RESP when counter is 0.
REQ-024 Word read and address/error capture SHALL occur at the edge entering RESP; o_rsp_data/addr/err SHALL hold stable while o_rsp_valid=1 and i_rsp_ready=0.
REQ-025 RESP with i_rsp_ready=1: new accepted request -> WAIT (or RESP if P_LATENCY=1); else -> IDLE with o_rsp_valid=0 next cycle.
REQ-026 o_rsp_err=1 when i_req_addr[1:0]!=0 or word index >= P_DEPTH_WORDS; then o_rsp_data SHALL be 0.
REQ-027 Word index SHALL be i_req_addr[P_ADDR_WIDTH-1:2]; no wrap-around.
REQ-028 i_ld_en SHALL write i_ld_data to word i_ld_addr[..:2] when index in range; out-of-range loads ignored.
REQ-029 Load and response-capture at the same edge to the same word SHALL return pre-write data.
REQ-030 i_flush=1 at any edge SHALL force IDLE, o_rsp_valid=0 next cycle, no accept that cycle; the flushed response is never presented.
REQ-031 Priority: i_rst > i_flush > handshake.

Reset
REQ-032 i_rst=1 at an edge SHALL set state IDLE, counter 0, o_rsp_valid=0, o_rsp_data=0, o_rsp_addr=0, o_rsp_err=0.
REQ-033 Reset SHALL not clear storage contents; i_ld_en ignored while i_rst=1.
REQ-034 Reset mid-WAIT or mid-RESP SHALL discard the pending response.

Verification
REQ-035 Preload word 4 = 0x00500093; P_LATENCY=2; request 0x10 accepted at T, i_rsp_ready=1 -> o_rsp_valid at T+2 only, data 0x00500093, addr 0x10, err 0.
REQ-036 Hold i_rsp_ready=0 for 3 cycles in RESP -> valid/data/addr stable, o_req_ready=0; release -> IDLE.
REQ-037 Request 0x12 -> err=1, data 0; request P_DEPTH_WORDS*4 -> err=1, data 0.
REQ-038 Back-to-back requests 0x0, 0x4, 0x8 with i_rsp_ready=1, P_LATENCY=1 -> one response per cycle, in order.
REQ-039 i_flush in WAIT and in RESP -> o_rsp_valid=0 next cycle, flushed data never seen; i_rst mid-WAIT -> all outputs 0, storage retained.
REQ-040 Load word 4 = 0xDEADBEEF at the same edge the FSM enters RESP for 0x10 -> old data returned; next read of 0x10 returns 0xDEADBEEF.
